// File: rtl/edge_counter_multi_if.sv
// Command and record-stream handshake bundle for edge_counter_multi.
interface edge_counter_multi_if #(
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned TS_WIDTH   = 64
) ();
   localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned REC_W = TS_WIDTH + CHW + DATA_WIDTH;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [NUM_CH-1:0] cmd_mask;
   logic [31:0]       window_len;
   logic              out_valid;
   logic              out_ready;
   logic [REC_W-1:0]  out_data;

   modport master (
      output cmd_valid, cmd_op, cmd_mask, window_len, out_ready,
      input  cmd_ready, out_valid, out_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_mask, window_len, out_ready,
      output cmd_ready, out_valid, out_data
   );
endinterface

// File: rtl/edge_counter_multi.sv
// Multi-channel synchronous rising-edge counter with free-run and gated-window
// modes; snapshots are queued as {timestamp, ch_idx, count} records.
module edge_counter_multi #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned TS_WIDTH    = 64,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                clk,
   input  logic                internal_reset,
   input  logic [NUM_CH-1:0]   input_sig,
   input  logic [TS_WIDTH-1:0] timestamp,
   edge_counter_multi_if.slave bus,
   output logic [NUM_CH-1:0]   sat_flags,
   output logic                drop_flag
);
   localparam int unsigned CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned REC_W  = TS_WIDTH + CHW + DATA_WIDTH;
   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

   localparam logic [2:0] OP_START  = 3'd1;
   localparam logic [2:0] OP_STOP   = 3'd2;
   localparam logic [2:0] OP_SAVE   = 3'd3;
   localparam logic [2:0] OP_CLEAR  = 3'd4;
   localparam logic [2:0] OP_WINDOW = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_WIN, S_DRAIN} state_t;

   state_t                    state_q;
   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0]         prev_q;
   logic [NUM_CH-1:0]         rise_c;
   logic [NUM_CH-1:0]         en_q;
   logic [NUM_CH-1:0]         clr_c;
   logic                      clr_drop_c;
   logic                      cmd_fire_c;
   logic                      latch_c;
   logic [NUM_CH-1:0]         latch_mask_c;
   logic [DATA_WIDTH-1:0]     cnt_q [NUM_CH];
   logic [DATA_WIDTH-1:0]     snap_cnt_q [NUM_CH];
   logic [TS_WIDTH-1:0]       snap_ts_q;
   logic [NUM_CH-1:0]         snap_mask_q;
   logic [NUM_CH-1:0]         snap_rest_c;
   logic [31:0]               win_cnt_q;
   logic [CHW-1:0]            drain_idx_c;
   logic [REC_W-1:0]          push_data_c;
   logic                      push_c;
   logic                      pop_c;
   logic                      full_c;
   logic                      push_ok_c;
   logic                      drop_c;
   logic [REC_W-1:0]          mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_q;
   logic [PTR_W-1:0]          rd_ptr_q;
   logic [PTR_W-1:0]          rd_next_c;
   logic [FCNT_W-1:0]         fcount_q;
   logic [FCNT_W-1:0]         remain_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Input synchroniser chain plus previous-value flop for edge detection.
   always_ff @(posedge clk or posedge internal_reset) begin
      if (internal_reset) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], input_sig};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_c     = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign cmd_fire_c = bus.cmd_valid & bus.cmd_ready;

   // Command decode: counter clears and snapshot trigger for this cycle.
   always_comb begin
      clr_c        = '0;
      clr_drop_c   = 1'b0;
      latch_c      = 1'b0;
      latch_mask_c = '0;
      if (state_q == S_IDLE && cmd_fire_c) begin
         if (bus.cmd_op == OP_CLEAR) begin
            clr_c      = bus.cmd_mask;
            clr_drop_c = &bus.cmd_mask;
         end else if (bus.cmd_op == OP_WINDOW) begin
            clr_c = bus.cmd_mask;
         end else if (bus.cmd_op == OP_SAVE) begin
            latch_c      = |bus.cmd_mask;
            latch_mask_c = bus.cmd_mask;
         end
      end else if (state_q == S_WIN && !(cmd_fire_c && bus.cmd_op == OP_STOP)
                   && win_cnt_q <= 32'd1) begin
         latch_c      = |en_q;
         latch_mask_c = en_q;
      end
   end

   // Per-channel saturating counters; a clear wins over a same-cycle edge.
   always_ff @(posedge clk or posedge internal_reset) begin
      if (internal_reset) begin
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
         sat_flags <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (clr_c[i]) begin
               cnt_q[i]     <= '0;
               sat_flags[i] <= 1'b0;
            end else if (en_q[i] && rise_c[i] && cnt_q[i] != CNT_MAX) begin
               cnt_q[i] <= cnt_q[i] + DATA_WIDTH'(1);
               if (cnt_q[i] == CNT_MAX - DATA_WIDTH'(1)) sat_flags[i] <= 1'b1;
            end
         end
      end
   end

   // Lowest pending channel in the drain mask.
   always_comb begin
      drain_idx_c = '0;
      for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
         if (snap_mask_q[i]) drain_idx_c = CHW'(i);
      end
   end

   assign snap_rest_c = snap_mask_q & (snap_mask_q - NUM_CH'(1));
   assign push_c      = (state_q == S_DRAIN);
   assign push_data_c = {snap_ts_q, drain_idx_c, snap_cnt_q[drain_idx_c]};

   // Control FSM: enables, window down-counter, snapshot and drain sequencing.
   always_ff @(posedge clk or posedge internal_reset) begin
      if (internal_reset) begin
         state_q       <= S_IDLE;
         en_q          <= '0;
         win_cnt_q     <= '0;
         snap_mask_q   <= '0;
         snap_ts_q     <= '0;
         bus.cmd_ready <= 1'b1;
         for (int i = 0; i < NUM_CH; i++) snap_cnt_q[i] <= '0;
      end else begin
         if (latch_c) begin
            snap_ts_q   <= timestamp;
            snap_mask_q <= latch_mask_c;
            for (int i = 0; i < NUM_CH; i++) snap_cnt_q[i] <= cnt_q[i];
         end
         case (state_q)
            S_IDLE: begin
               if (cmd_fire_c) begin
                  case (bus.cmd_op)
                     OP_START: en_q <= en_q | bus.cmd_mask;
                     OP_STOP:  en_q <= en_q & ~bus.cmd_mask;
                     OP_SAVE: begin
                        if (latch_c) begin
                           state_q       <= S_DRAIN;
                           bus.cmd_ready <= 1'b0;
                        end
                     end
                     OP_WINDOW: begin
                        en_q      <= bus.cmd_mask;
                        win_cnt_q <= (bus.window_len == 32'd0) ? 32'd1 : bus.window_len;
                        state_q   <= S_WIN;
                     end
                     default: ;
                  endcase
               end
            end
            S_WIN: begin
               if (cmd_fire_c && bus.cmd_op == OP_STOP) begin
                  en_q    <= '0;
                  state_q <= S_IDLE;
               end else if (win_cnt_q <= 32'd1) begin
                  win_cnt_q     <= '0;
                  en_q          <= '0;
                  state_q       <= latch_c ? S_DRAIN : S_IDLE;
                  bus.cmd_ready <= !latch_c;
               end else begin
                  win_cnt_q <= win_cnt_q - 32'd1;
               end
            end
            S_DRAIN: begin
               snap_mask_q <= snap_rest_c;
               if (snap_rest_c == '0) begin
                  state_q       <= S_IDLE;
                  bus.cmd_ready <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pop_c     = bus.out_valid & bus.out_ready;
   assign full_c    = (fcount_q == FCNT_W'(FIFO_DEPTH));
   assign push_ok_c = push_c & (~full_c | pop_c);
   assign drop_c    = push_c & full_c & ~pop_c;
   assign remain_c  = fcount_q - FCNT_W'(pop_c);
   assign rd_next_c = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;

   // Record storage; contents need no reset since occupancy gates the reads.
   always_ff @(posedge clk) begin
      if (push_ok_c) mem_q[wr_ptr_q] <= push_data_c;
   end

   // FIFO pointers, occupancy and registered head-of-queue output.
   always_ff @(posedge clk or posedge internal_reset) begin
      if (internal_reset) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fcount_q      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
         drop_flag     <= 1'b0;
      end else begin
         if (push_ok_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
         rd_ptr_q      <= rd_next_c;
         fcount_q      <= fcount_q + FCNT_W'(push_ok_c) - FCNT_W'(pop_c);
         bus.out_valid <= (remain_c != '0) | push_ok_c;
         if (remain_c != '0) bus.out_data <= mem_q[rd_next_c];
         else if (push_ok_c) bus.out_data <= push_data_c;
         if (clr_drop_c)  drop_flag <= 1'b0;
         else if (drop_c) drop_flag <= 1'b1;
      end
   end
endmodule

// File: tb/tb_edge_counter_multi.sv
// Directed bench for edge_counter_multi: a 16-bit and a 4-bit instance share stimulus.
module tb_edge_counter_multi;
   localparam logic [2:0] OP_START  = 3'd1;
   localparam logic [2:0] OP_STOP   = 3'd2;
   localparam logic [2:0] OP_SAVE   = 3'd3;
   localparam logic [2:0] OP_CLEAR  = 3'd4;
   localparam logic [2:0] OP_WINDOW = 3'd5;

   logic        clk;
   logic        internal_reset;
   logic [3:0]  input_sig;
   logic [63:0] timestamp;
   logic        cmd_valid;
   logic [2:0]  cmd_op;
   logic [3:0]  cmd_mask;
   logic [31:0] window_len;
   logic        out_ready;
   logic [3:0]  sat0, sat1;
   logic        drop0, drop1;
   int          n_cmp = 0;
   int          n_bad = 0;

   edge_counter_multi_if #(.NUM_CH(4), .DATA_WIDTH(16), .TS_WIDTH(64)) cif0 ();
   edge_counter_multi_if #(.NUM_CH(4), .DATA_WIDTH(4),  .TS_WIDTH(64)) cif1 ();

   assign cif0.cmd_valid  = cmd_valid;
   assign cif0.cmd_op     = cmd_op;
   assign cif0.cmd_mask   = cmd_mask;
   assign cif0.window_len = window_len;
   assign cif0.out_ready  = out_ready;
   assign cif1.cmd_valid  = cmd_valid;
   assign cif1.cmd_op     = cmd_op;
   assign cif1.cmd_mask   = cmd_mask;
   assign cif1.window_len = window_len;
   assign cif1.out_ready  = out_ready;

   edge_counter_multi #(.NUM_CH(4), .DATA_WIDTH(16), .TS_WIDTH(64), .SYNC_STAGES(2), .FIFO_DEPTH(8)) dut0 (
      .clk(clk), .internal_reset(internal_reset), .input_sig(input_sig),
      .timestamp(timestamp), .bus(cif0), .sat_flags(sat0), .drop_flag(drop0));

   edge_counter_multi #(.NUM_CH(4), .DATA_WIDTH(4), .TS_WIDTH(64), .SYNC_STAGES(2), .FIFO_DEPTH(8)) dut1 (
      .clk(clk), .internal_reset(internal_reset), .input_sig(input_sig),
      .timestamp(timestamp), .bus(cif1), .sat_flags(sat1), .drop_flag(drop1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      timestamp = 64'd0;
      forever @(negedge clk) timestamp = timestamp + 64'd1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [81:0] rec0(input logic [63:0] ts, input int ch, input int cnt);
      return {ts, 2'(ch), 16'(cnt)};
   endfunction

   function automatic logic [69:0] rec1(input logic [63:0] ts, input int ch, input int cnt);
      return {ts, 2'(ch), 4'(cnt)};
   endfunction

   task automatic do_reset();
      @(negedge clk);
      internal_reset = 1'b1;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = '0; window_len = '0;
      out_ready = 1'b0; input_sig = '0;
      repeat (2) @(negedge clk);
      internal_reset = 1'b0;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [3:0] mask,
                           input logic [31:0] len, output logic [63:0] ts_acc);
      int n = 0;
      @(negedge clk);
      while (!cif0.cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cif0.cmd_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cif0.cmd_ready);
      end
      cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; window_len = len;
      @(posedge clk);
      ts_acc = timestamp;
      #1 cmd_valid = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] mask, input int high, input int low);
      @(negedge clk);
      input_sig = mask;
      repeat (high) @(negedge clk);
      input_sig = '0;
      repeat (low - 1) @(negedge clk);
   endtask

   task automatic pop_rec(output logic [81:0] d0, output logic [69:0] d1, output bit ok);
      int n = 0;
      @(negedge clk);
      while (!cif0.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      ok = cif0.out_valid;
      d0 = cif0.out_data;
      d1 = cif1.out_data;
      if (ok) begin
         out_ready = 1'b1;
         @(posedge clk);
         #1 out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [63:0] ts;
      do_reset();
      n_cmp++; if (cif0.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b need 0", cif0.out_valid); end
      n_cmp++; if (cif0.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rst_cmd_ready: got %b need 1", cif0.cmd_ready); end
      n_cmp++; if (cif0.out_data !== 82'd0) begin n_bad++; $display("FAIL rst_out_data: got %h need 0", cif0.out_data); end
      n_cmp++; if (sat0 !== 4'd0 || drop0 !== 1'b0) begin n_bad++; $display("FAIL rst_flags: sat=%b drop=%b need 0", sat0, drop0); end
      send_cmd(OP_SAVE, 4'b0000, 32'd0, ts);
      repeat (4) begin
         @(negedge clk);
         n_cmp++; if (cif0.cmd_ready !== 1'b1 || cif0.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL empty_save: cmd_ready=%b out_valid=%b need 1/0", cif0.cmd_ready, cif0.out_valid);
         end
      end
   endtask

   task automatic test_latency();
      logic [63:0] ts, ts2;
      logic [81:0] d0;
      logic [69:0] d1;
      bit ok;
      do_reset();
      send_cmd(OP_START, 4'b0001, 32'd0, ts);
      @(negedge clk);
      input_sig = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = OP_SAVE; cmd_mask = 4'b0001;
      @(posedge clk);
      ts = timestamp;
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      input_sig = '0;
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts, 0, 0)) begin n_bad++; $display("FAIL latency_same_cycle: got %h need %h", d0, rec0(ts, 0, 0)); end
      send_cmd(OP_SAVE, 4'b0001, 32'd0, ts2);
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts2, 0, 1)) begin n_bad++; $display("FAIL latency_next_cycle: got %h need %h", d0, rec0(ts2, 0, 1)); end
   endtask

   task automatic test_free_run();
      logic [63:0] ts;
      logic [81:0] d0;
      logic [69:0] d1;
      bit ok;
      do_reset();
      send_cmd(OP_START, 4'b0001, 32'd0, ts);
      repeat (10) pulse(4'b0001, 2, 2);
      repeat (5) @(negedge clk);
      send_cmd(OP_SAVE, 4'b0001, 32'd0, ts);
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts, 0, 10)) begin n_bad++; $display("FAIL free_run_rec: got %h need %h", d0, rec0(ts, 0, 10)); end
      @(negedge clk);
      n_cmp++; if (cif0.out_valid !== 1'b0) begin n_bad++; $display("FAIL free_run_single: out_valid=%b need 0", cif0.out_valid); end
   endtask

   task automatic test_window();
      logic [63:0] ts;
      logic [81:0] d0;
      logic [69:0] d1;
      bit ok;
      int low_cycles = 0;
      do_reset();
      send_cmd(OP_WINDOW, 4'b0011, 32'd100, ts);
      repeat (20) pulse(4'b0001, 2, 3);
      repeat (10) begin
         @(negedge clk);
         if (!cif0.cmd_ready) low_cycles++;
      end
      n_cmp++; if (low_cycles !== 2) begin n_bad++; $display("FAIL window_busy: cmd_ready low %0d cycles need 2", low_cycles); end
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts + 64'd100, 0, 20)) begin n_bad++; $display("FAIL window_ch0: got %h need %h", d0, rec0(ts + 64'd100, 0, 20)); end
      n_cmp++; if (!ok || d1 !== rec1(ts + 64'd100, 0, 15)) begin n_bad++; $display("FAIL window_ch0_narrow: got %h need %h", d1, rec1(ts + 64'd100, 0, 15)); end
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts + 64'd100, 1, 0)) begin n_bad++; $display("FAIL window_ch1: got %h need %h", d0, rec0(ts + 64'd100, 1, 0)); end
   endtask

   task automatic test_saturate();
      logic [63:0] ts;
      logic [81:0] d0;
      logic [69:0] d1;
      bit ok;
      do_reset();
      send_cmd(OP_START, 4'b0100, 32'd0, ts);
      repeat (20) pulse(4'b0100, 2, 2);
      repeat (5) @(negedge clk);
      n_cmp++; if (sat1 !== 4'b0100) begin n_bad++; $display("FAIL sat_flag_set: got %b need 0100", sat1); end
      n_cmp++; if (sat0 !== 4'b0000) begin n_bad++; $display("FAIL sat_flag_wide: got %b need 0000", sat0); end
      send_cmd(OP_SAVE, 4'b0100, 32'd0, ts);
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d1 !== rec1(ts, 2, 15)) begin n_bad++; $display("FAIL sat_hold: got %h need %h", d1, rec1(ts, 2, 15)); end
      n_cmp++; if (!ok || d0 !== rec0(ts, 2, 20)) begin n_bad++; $display("FAIL sat_wide_count: got %h need %h", d0, rec0(ts, 2, 20)); end
      send_cmd(OP_CLEAR, 4'b0100, 32'd0, ts);
      @(negedge clk);
      n_cmp++; if (sat1 !== 4'b0000) begin n_bad++; $display("FAIL sat_clear: got %b need 0000", sat1); end
      send_cmd(OP_SAVE, 4'b0100, 32'd0, ts);
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d1 !== rec1(ts, 2, 0)) begin n_bad++; $display("FAIL sat_cleared_count: got %h need %h", d1, rec1(ts, 2, 0)); end
   endtask

   task automatic test_fifo_overflow();
      logic [63:0] ts;
      logic [63:0] tsv [3];
      logic [81:0] d0;
      logic [69:0] d1;
      bit ok;
      do_reset();
      send_cmd(OP_START, 4'b1111, 32'd0, ts);
      pulse(4'b1111, 2, 2);
      pulse(4'b1110, 2, 2);
      pulse(4'b1100, 2, 2);
      pulse(4'b1000, 2, 2);
      repeat (5) @(negedge clk);
      send_cmd(OP_STOP, 4'b1111, 32'd0, ts);
      for (int s = 0; s < 3; s++) send_cmd(OP_SAVE, 4'b1111, 32'd0, tsv[s]);
      repeat (8) @(negedge clk);
      n_cmp++; if (drop0 !== 1'b1) begin n_bad++; $display("FAIL fifo_drop_flag: got %b need 1", drop0); end
      for (int s = 0; s < 2; s++) begin
         for (int c = 0; c < 4; c++) begin
            pop_rec(d0, d1, ok);
            n_cmp++; if (!ok || d0 !== rec0(tsv[s], c, c + 1)) begin
               n_bad++; $display("FAIL fifo_order s%0d c%0d: got %h need %h", s, c, d0, rec0(tsv[s], c, c + 1));
            end
         end
      end
      @(negedge clk);
      n_cmp++; if (cif0.out_valid !== 1'b0) begin n_bad++; $display("FAIL fifo_empty_after: out_valid=%b need 0", cif0.out_valid); end
      send_cmd(OP_CLEAR, 4'b1111, 32'd0, ts);
      @(negedge clk);
      n_cmp++; if (drop0 !== 1'b0) begin n_bad++; $display("FAIL drop_clear: got %b need 0", drop0); end
   endtask

   task automatic test_win_abort();
      logic [63:0] ts;
      logic [81:0] d0;
      logic [69:0] d1;
      bit ok;
      do_reset();
      send_cmd(OP_WINDOW, 4'b0001, 32'd100, ts);
      repeat (10) pulse(4'b0001, 2, 3);
      send_cmd(OP_STOP, 4'b0001, 32'd0, ts);
      pulse(4'b0001, 2, 3);
      repeat (80) @(negedge clk);
      n_cmp++; if (cif0.out_valid !== 1'b0) begin n_bad++; $display("FAIL abort_no_record: out_valid=%b need 0", cif0.out_valid); end
      n_cmp++; if (cif0.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL abort_idle: cmd_ready=%b need 1", cif0.cmd_ready); end
      send_cmd(OP_SAVE, 4'b0001, 32'd0, ts);
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts, 0, 10)) begin n_bad++; $display("FAIL abort_partial: got %h need %h", d0, rec0(ts, 0, 10)); end
   endtask

   task automatic test_reset_drain();
      logic [63:0] ts;
      logic [81:0] d0;
      logic [69:0] d1;
      bit ok;
      do_reset();
      send_cmd(OP_START, 4'b0011, 32'd0, ts);
      repeat (2) pulse(4'b0011, 2, 2);
      repeat (5) @(negedge clk);
      send_cmd(OP_SAVE, 4'b1111, 32'd0, ts);
      @(posedge clk);
      @(posedge clk);
      #2;
      n_cmp++; if (cif0.out_valid !== 1'b1) begin n_bad++; $display("FAIL drain_queued: out_valid=%b need 1", cif0.out_valid); end
      internal_reset = 1'b1;
      #1;
      n_cmp++; if (cif0.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b need 0", cif0.out_valid); end
      n_cmp++; if (cif0.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cmd_ready: got %b need 1", cif0.cmd_ready); end
      @(negedge clk);
      internal_reset = 1'b0;
      send_cmd(OP_SAVE, 4'b0011, 32'd0, ts);
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts, 0, 0)) begin n_bad++; $display("FAIL reset_count_ch0: got %h need %h", d0, rec0(ts, 0, 0)); end
      pop_rec(d0, d1, ok);
      n_cmp++; if (!ok || d0 !== rec0(ts, 1, 0)) begin n_bad++; $display("FAIL reset_count_ch1: got %h need %h", d0, rec0(ts, 1, 0)); end
   endtask

   initial begin
      internal_reset = 1'b1;
      cmd_valid = 1'b0; cmd_op = 3'd0; cmd_mask = '0; window_len = '0;
      out_ready = 1'b0; input_sig = '0;
      test_reset();
      test_latency();
      test_free_run();
      test_window();
      test_saturate();
      test_fifo_overflow();
      test_win_abort();
      test_reset_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
